// File: rtl/mem_image_loader.sv
// Framed boot-image loader: streams ADDR/LEN/DATA/CSUM records into memory and
// releases the CPU at boot_pc once verified. Optional macro: LOADER_TIMEOUT_EN.
module mem_image_loader #(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 12,
    parameter bit HOLD_AT_RESET = 1'b1,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] boot_pc,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        seg_cnt,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, DONE, ERR} state_t;

    // Wide enough to hold base + N without overflow for any stream word.
    localparam int CW = ((DATA_W > ADDR_W) ? DATA_W : ADDR_W) + 2;
    localparam logic [CW-1:0] LIMIT = CW'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     off_q, off_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic [ADDR_W-1:0]   bootpc_q, bootpc_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic [7:0]          seg_q, seg_d;
    logic                xfer;
    logic                timeout_hit;
    logic [CW-1:0]       end_ext;

    // Handshake: a word moves on a rising edge where s_valid && s_ready; s_ready
    // is a pure function of state and never looks at s_valid.
    assign s_ready = (state_q == ADDR) || (state_q == LEN) ||
                     (state_q == DATA) || (state_q == CSUM);
    assign xfer    = s_valid && s_ready;
    assign end_ext = CW'(base_q) + CW'(s_data);

`ifdef LOADER_TIMEOUT_EN
    localparam int SW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    logic [SW-1:0] stall_q, stall_d;

    always_comb begin
        stall_d     = '0;
        timeout_hit = 1'b0;
        if (s_ready && !xfer) begin
            if (stall_q == SW'(TIMEOUT_CYC - 1)) timeout_hit = 1'b1;
            else                                  stall_d     = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end
`else
    // Constant zero: without the stall counter the loader waits forever.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        off_d    = off_q;
        sum_d    = sum_q;
        we_d     = 1'b0;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        bootpc_d = bootpc_q;
        done_d   = done_q;
        err_d    = err_q;
        code_d   = code_q;
        seg_d    = seg_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = ADDR;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                    seg_d   = 8'd0;
                end
            end
            ADDR: begin
                if (xfer) begin
                    base_d  = ADDR_W'(s_data);
                    state_d = LEN;
                end
            end
            LEN: begin
                if (xfer) begin
                    if (s_data == '0) begin
                        bootpc_d = base_q;
                        done_d   = 1'b1;
                        hold_d   = 1'b0;
                        state_d  = DONE;
                    end else if (end_ext > LIMIT) begin
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                        state_d = ERR;
                    end else begin
                        len_d   = (ADDR_W + 1)'(s_data);
                        off_d   = '0;
                        sum_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    adr_d   = base_q + off_q[ADDR_W-1:0];
                    wdata_d = s_data;
                    sum_d   = sum_q + s_data;
                    off_d   = off_q + 1'b1;
                    if (off_q + 1'b1 == len_q) state_d = CSUM;
                end
            end
            CSUM: begin
                if (xfer) begin
                    if (s_data == sum_q) begin
                        seg_d   = (seg_q == 8'hFF) ? seg_q : seg_q + 8'd1;
                        state_d = ADDR;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = ERR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout_hit) begin
            err_d   = 1'b1;
            code_d  = 2'd3;
            state_d = ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            off_q    <= '0;
            sum_q    <= '0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            hold_q   <= HOLD_AT_RESET;
            bootpc_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
            seg_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            off_q    <= off_d;
            sum_q    <= sum_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            bootpc_q <= bootpc_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            seg_q    <= seg_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_adr   = adr_q;
    assign mem_data  = wdata_q;
    assign cpu_hold  = hold_q;
    assign boot_pc   = bootpc_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign seg_cnt   = seg_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_image_loader.sv
// Directed bench for mem_image_loader: table of single-segment loads plus
// hand-written boot, checksum, reset and stall sequences.
module tb_mem_image_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = 16'h0;
    logic        mem_we;
    logic [11:0] mem_adr;
    logic [15:0] mem_data;
    logic        cpu_hold;
    logic [11:0] boot_pc;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  seg_cnt;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    bit gap_en = 1'b0;
    logic [27:0] exp_q[$];
    logic [15:0] stream_q[$];

    mem_image_loader #(.DATA_W(16), .ADDR_W(12), .HOLD_AT_RESET(1'b1), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .mem_we(mem_we), .mem_adr(mem_adr), .mem_data(mem_data),
        .cpu_hold(cpu_hold), .boot_pc(boot_pc), .done(done), .err(err),
        .err_code(err_code), .seg_cnt(seg_cnt), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [11:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %0h:%0h expected none", mem_adr, mem_data);
            end else begin
                logic [27:0] e;
                e = exp_q.pop_front();
                if ({mem_adr, mem_data} !== e) begin
                    errors++;
                    $display("FAIL write: got %0h:%0h expected %0h:%0h",
                             mem_adr, mem_data, e[27:16], e[15:0]);
                end
            end
        end
    end

    // drivers (all entered and left on a falling edge)
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        bit ok;
        int gap;
        ok  = 1'b0;
        gap = gap_en ? int'($urandom_range(0, 5)) : 0;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 64; i++) begin
            if (s_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL handshake: got no s_ready expected accept of %0h", w);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},    mem_we,   1'b0);
        chk({tag, "_adr"},   mem_adr,  12'h0);
        chk({tag, "_data"},  mem_data, 16'h0);
        chk({tag, "_hold"},  cpu_hold, 1'b1);
        chk({tag, "_pc"},    boot_pc,  12'h0);
        chk({tag, "_done"},  done,     1'b0);
        chk({tag, "_err"},   err,      1'b0);
        chk({tag, "_code"},  err_code, 2'd0);
        chk({tag, "_seg"},   seg_cnt,  8'd0);
        chk({tag, "_ready"}, s_ready,  1'b0);
    endtask

    // full three-segment boot image; checks cpu_hold release on the end record
    task automatic run_boot(input string tag);
        pulse_start();
        stream_q = '{16'h010, 16'd6, 16'h0A05, 16'h1250, 16'h1360, 16'h0E11, 16'h70FF,
                     16'hFFFF, 16'hAEC4, 16'h050, 16'd1, 16'h0007, 16'h0007,
                     16'h060, 16'd1, 16'h0002, 16'h0002, 16'h010, 16'd0};
        push_exp(12'h010, 16'h0A05); push_exp(12'h011, 16'h1250);
        push_exp(12'h012, 16'h1360); push_exp(12'h013, 16'h0E11);
        push_exp(12'h014, 16'h70FF); push_exp(12'h015, 16'hFFFF);
        push_exp(12'h050, 16'h0007); push_exp(12'h060, 16'h0002);
        for (int i = 0; i < stream_q.size() - 1; i++) send_word(stream_q[i]);
        chk({tag, "_hold_before_end"}, cpu_hold, 1'b1);
        chk({tag, "_done_before_end"}, done, 1'b0);
        send_word(stream_q[stream_q.size() - 1]);
        chk({tag, "_hold_released"}, cpu_hold, 1'b0);
        chk({tag, "_done"}, done, 1'b1);
        @(negedge clk);
        chk({tag, "_seg"}, seg_cnt, 8'd3);
        chk({tag, "_pc"}, boot_pc, 12'h010);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_code"}, err_code, 2'd0);
        chk({tag, "_ready"}, s_ready, 1'b0);
        chk({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    typedef struct packed {
        logic [15:0]       addr_w;
        logic [15:0]       len;
        logic [3:0][15:0]  d;
        logic [15:0]       csum;
        logic [11:0]       exp_pc;
        logic [1:0]        exp_code;
        logic [7:0]        exp_seg;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{addr_w:16'h7100, len:16'd2, d:{16'h0, 16'h0, 16'h0002, 16'h0001},
                    csum:16'h0003, exp_pc:12'h200, exp_code:2'd0, exp_seg:8'd1};
        vecs[1] = '{addr_w:16'h0FFE, len:16'd2, d:{16'h0, 16'h0, 16'h2222, 16'h1111},
                    csum:16'h3333, exp_pc:12'h000, exp_code:2'd0, exp_seg:8'd1};
        vecs[2] = '{addr_w:16'h0FFE, len:16'd3, d:'0,
                    csum:16'h0, exp_pc:12'h000, exp_code:2'd2, exp_seg:8'd0};
        vecs[3] = '{addr_w:16'h0050, len:16'd1, d:{16'h0, 16'h0, 16'h0, 16'h0007},
                    csum:16'h0008, exp_pc:12'h000, exp_code:2'd1, exp_seg:8'd0};
        vecs[4] = '{addr_w:16'h0000, len:16'd4, d:{16'h8000, 16'h8000, 16'h0001, 16'hFFFF},
                    csum:16'h0000, exp_pc:12'h123, exp_code:2'd0, exp_seg:8'd1};
        vecs[5] = '{addr_w:16'h0FFF, len:16'd1, d:{16'h0, 16'h0, 16'h0, 16'hABCD},
                    csum:16'hABCD, exp_pc:12'hFFF, exp_code:2'd0, exp_seg:8'd1};
        vecs[6] = '{addr_w:16'h0002, len:16'h0FFF, d:'0,
                    csum:16'h0, exp_pc:12'h000, exp_code:2'd2, exp_seg:8'd0};
        vecs[7] = '{addr_w:16'h0ABC, len:16'd0, d:'0,
                    csum:16'h0, exp_pc:12'hABC, exp_code:2'd0, exp_seg:8'd0};

        @(negedge clk);
        do_reset();
        check_reset_outputs("reset");

        // table-driven single-segment loads
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v = vecs[i];
            do_reset();
            pulse_start();
            send_word(v.addr_w);
            send_word(v.len);
            if (v.exp_code != 2'd2 && v.len != 16'd0) begin
                for (int j = 0; j < int'(v.len); j++) begin
                    push_exp(v.addr_w[11:0] + 12'(j), v.d[j]);
                    send_word(v.d[j]);
                end
                send_word(v.csum);
                if (v.exp_code == 2'd0) begin
                    send_word({4'h0, v.exp_pc});
                    send_word(16'd0);
                end
            end
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d_done", i), done, v.exp_code == 2'd0);
            chk($sformatf("vec%0d_err", i), err, v.exp_code != 2'd0);
            chk($sformatf("vec%0d_code", i), err_code, v.exp_code);
            chk($sformatf("vec%0d_seg", i), seg_cnt, v.exp_seg);
            chk($sformatf("vec%0d_pc", i), boot_pc, v.exp_pc);
            chk($sformatf("vec%0d_hold", i), cpu_hold, v.exp_code != 2'd0);
            chk($sformatf("vec%0d_ready", i), s_ready, 1'b0);
            chk($sformatf("vec%0d_writes_left", i), exp_q.size(), 0);
        end

        // normal boot, back-to-back then with random gaps
        do_reset();
        run_boot("boot");
        do_reset();
        gap_en = 1'b1;
        run_boot("boot_gaps");
        gap_en = 1'b0;

        // bad checksum: six writes, then nothing more is accepted
        do_reset();
        pulse_start();
        push_exp(12'h010, 16'h0A05); push_exp(12'h011, 16'h1250);
        push_exp(12'h012, 16'h1360); push_exp(12'h013, 16'h0E11);
        push_exp(12'h014, 16'h70FF); push_exp(12'h015, 16'hFFFF);
        stream_q = '{16'h010, 16'd6, 16'h0A05, 16'h1250, 16'h1360, 16'h0E11,
                     16'h70FF, 16'hFFFF, 16'hAEC5};
        foreach (stream_q[i]) send_word(stream_q[i]);
        chk("csum_err", err, 1'b1);
        chk("csum_code", err_code, 2'd1);
        chk("csum_hold", cpu_hold, 1'b1);
        begin
            logic any_ready;
            any_ready = 1'b0;
            s_valid = 1'b1;
            for (int k = 0; k < 10; k++) begin
                s_data = 16'h0100 + 16'(k);
                any_ready = any_ready | s_ready;
                @(negedge clk);
            end
            s_valid = 1'b0;
            chk("csum_ready_after_err", any_ready, 1'b0);
        end
        chk("csum_writes_left", exp_q.size(), 0);

        // reset in the middle of segment 1
        do_reset();
        pulse_start();
        push_exp(12'h010, 16'h0A05); push_exp(12'h011, 16'h1250); push_exp(12'h012, 16'h1360);
        send_word(16'h010); send_word(16'd6);
        send_word(16'h0A05); send_word(16'h1250); send_word(16'h1360);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_we_next", mem_we, 1'b0);
        chk("midrst_writes_left", exp_q.size(), 0);
        run_boot("after_rst");

        // stall after the LEN word
        do_reset();
        pulse_start();
        send_word(16'h010);
        send_word(16'd2);
`ifdef LOADER_TIMEOUT_EN
        repeat (15) @(negedge clk);
        chk("stall_err_early", err, 1'b0);
        @(negedge clk);
        chk("stall_err", err, 1'b1);
        chk("stall_code", err_code, 2'd3);
        chk("stall_hold", cpu_hold, 1'b1);
`else
        repeat (1000) @(negedge clk);
        chk("stall_err", err, 1'b0);
        chk("stall_code", err_code, 2'd0);
        chk("stall_ready", s_ready, 1'b1);
`endif
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
